pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage pipeline around the execute-stage ALU.
- Decides PC/IF-ID write enables, ID/EX bubble insertion, IF-ID flush on redirect, and ALU operand forwarding selects.
- Owns the halt sequence: HALT decode, pipeline drain, then stop.
- Sits beside the decode stage. Takes hazard inputs from ID, EX and MEM pipeline registers.

Parameters:
- DRAIN_CYCLES, 3, cycles spent in DRAIN after HALT leaves ID, before halted asserts (range 1..15).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- id_valid  in  1  ID holds a real instruction.
- id_op  in  6  ID opcode.
- id_rs_add  in  5  ID source register A address.
- id_rt_add  in  5  ID source register B address.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_reg_write  in  1  EX instruction writes a register.
- ex_mem_read  in  1  EX instruction is a load (LDW).
- ex_rd_add  in  5  EX destination address.
- mem_reg_write  in  1  MEM instruction writes a register.
- mem_rd_add  in  5  MEM destination address.
- ex_redirect  in  1  EX resolved a taken BZ/BEQ or a JR.
- pc_write_en  out  1  PC may advance.
- ifid_write_en  out  1  IF/ID register may load.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EX loads a NOP (all controls 0).
- fwd_a_sel  out  2  operand A source: 0=regfile, 1=EX result, 2=MEM result.
- fwd_b_sel  out  2  operand B source, same encoding.
- halted  out  1  pipeline stopped.
- stall_count  out  CNT_W  load-use stall cycles.
- flush_count  out  CNT_W  redirect flushes.
- retire_count  out  CNT_W  non-bubble instructions issued into EX.

Behaviour:
- State machine states: RUN, DRAIN, HALTED. State, drain counter and all counters are registered.
- Control outputs are combinational from state and current inputs, so they take effect in the same cycle.
- Reset (reset==0 at a clk edge, from any state including mid-drain):
  - state goes to RUN; drain counter and all counters go to 0.
  - While reset is low: pc_write_en=1, ifid_write_en=1, ifid_flush=0, idex_bubble=1, fwd selects=0, halted=0.
- Register 0 is never a hazard or forwarding source.
- Load-use hazard (RUN only), when all of the following hold:
  - id_valid=1, ex_mem_read=1, ex_rd_add!=0;
  - ex_rd_add==id_rs_add, or (id_uses_rt=1 and ex_rd_add==id_rt_add).
  - Response: pc_write_en=0, ifid_write_en=0, idex_bubble=1. Exactly one stall cycle per load; the next cycle re-evaluates.
- Forwarding, per operand:
  - EX match (reg_write=1, rd!=0, rd==source) → sel 1.
  - Else MEM match → sel 2.
  - Else → sel 0.
  - EX beats MEM when both match.
  - fwd_b_sel is 0 when id_uses_rt=0.
- Redirect (ex_redirect=1, RUN or DRAIN):
  - ifid_flush=1 and idex_bubble=1; pc_write_en=1 so the PC loads the target.
  - Redirect has priority over load-use stall and over HALT in ID. A discarded HALT does not start a drain.
  - A redirect while in DRAIN returns the state to RUN.
- HALT (id_op==6'b010001, id_valid=1, no redirect, RUN):
  - Next state is DRAIN, drain counter loads DRAIN_CYCLES.
  - From that cycle on: pc_write_en=0, ifid_write_en=0, idex_bubble=1.
- DRAIN:
  - Counter decrements each cycle; at 0 → HALTED.
  - Forwarding selects keep operating so older instructions complete.
- HALTED:
  - halted=1, pc_write_en=0, ifid_write_en=0, idex_bubble=1, fwd selects=0.
  - Exits only via reset.
- Counters:
  - stall_count +1 per load-use stall cycle.
  - flush_count +1 per redirect cycle.
  - retire_count +1 per cycle with idex_bubble=0 and id_valid=1.
  - All saturate at all-ones; no wrap.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined: the three counters are implemented as specified.
- Not defined: counter registers are removed; stall_count, flush_count and retire_count are tied to 0. All other behaviour is unchanged.

Test Plan:
- LDW r5 in EX (ex_mem_read=1, ex_rd_add=5), ADD reading r5 in ID → one cycle pc_write_en=0, idex_bubble=1; next cycle ADD issues with fwd_a_sel=2; stall_count=1.
- ex_rd_add=3 and mem_rd_add=3, both reg_write=1, id_rs_add=3 → fwd_a_sel=1. Same case with rd=0 → fwd_a_sel=0, no stall.
- ex_redirect=1 together with a load-use hazard → ifid_flush=1, idex_bubble=1, pc_write_en=1; flush_count=1, stall_count=0.
- HALT in ID, DRAIN_CYCLES=3 → halted rises exactly 4 clocks after the HALT-decode edge; pc_write_en=0 throughout.
- HALT in ID together with ex_redirect=1 → state stays RUN, halted never asserts.
- reset=0 for one clock during DRAIN → state RUN, counters 0, halted=0, pc_write_en=1 on the next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: sequencing controller for the 5-stage pipeline around the EX-stage ALU.
// Resolves load-use stalls, redirect flushes, ALU operand forwarding and the HALT/drain sequence.
//
// Ports:
//   clk, reset           pipeline clock; synchronous active-low reset
//   id_*                 decode-stage instruction: valid, opcode, rs/rt addresses, rt-used flag
//   ex_*                 EX-stage destination info, load flag, taken-redirect flag
//   mem_*                MEM-stage destination info
//   pc_write_en          PC may advance
//   ifid_write_en        IF/ID register may load
//   ifid_flush           IF/ID loads a NOP
//   idex_bubble          ID/EX loads a NOP
//   fwd_a_sel/fwd_b_sel  operand source: 0=regfile, 1=EX result, 2=MEM result
//   halted               pipeline stopped (leaves only through reset)
//   stall_count, flush_count, retire_count  saturating performance counters
//
// Build option: define PIPE_PERF_CNT_EN to implement the performance counters; otherwise
// they read as 0.
module pipe_hazard_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [5:0]       id_op,
   input  logic [4:0]       id_rs_add,
   input  logic [4:0]       id_rt_add,
   input  logic             id_uses_rt,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd_add,
   input  logic             mem_reg_write,
   input  logic [4:0]       mem_rd_add,
   input  logic             ex_redirect,
   output logic             pc_write_en,
   output logic             ifid_write_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             halted,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic [CNT_W-1:0] retire_count
);

   localparam logic [5:0] OpHalt = 6'b010001;

   typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

   state_e     state_q, state_d;
   logic [3:0] drain_q, drain_d;

   logic       ex_a_hit, ex_b_hit, mem_a_hit, mem_b_hit;
   logic [1:0] fwd_a, fwd_b;
   logic       load_use, is_halt;
   logic       stall_ev, flush_ev, retire_ev;

   // Register 0 is hardwired, so it never counts as a producer.
   always_comb begin
      ex_a_hit  = ex_reg_write && (ex_rd_add != 5'd0) && (ex_rd_add == id_rs_add);
      ex_b_hit  = ex_reg_write && (ex_rd_add != 5'd0) && (ex_rd_add == id_rt_add);
      mem_a_hit = mem_reg_write && (mem_rd_add != 5'd0) && (mem_rd_add == id_rs_add);
      mem_b_hit = mem_reg_write && (mem_rd_add != 5'd0) && (mem_rd_add == id_rt_add);
      // The younger (EX) result wins over the older (MEM) one.
      fwd_a     = ex_a_hit ? 2'd1 : (mem_a_hit ? 2'd2 : 2'd0);
      fwd_b     = !id_uses_rt ? 2'd0 : (ex_b_hit ? 2'd1 : (mem_b_hit ? 2'd2 : 2'd0));
      load_use  = id_valid && ex_mem_read && (ex_rd_add != 5'd0) &&
                  ((ex_rd_add == id_rs_add) || (id_uses_rt && (ex_rd_add == id_rt_add)));
      is_halt   = id_valid && (id_op == OpHalt);
   end

   always_comb begin
      state_d       = state_q;
      drain_d       = drain_q;
      pc_write_en   = 1'b1;
      ifid_write_en = 1'b1;
      ifid_flush    = 1'b0;
      idex_bubble   = 1'b0;
      fwd_a_sel     = 2'd0;
      fwd_b_sel     = 2'd0;
      halted        = 1'b0;
      stall_ev      = 1'b0;
      flush_ev      = 1'b0;
      if (!reset) begin
         state_d     = StRun;
         drain_d     = 4'd0;
         idex_bubble = 1'b1;
      end else begin
         unique case (state_q)
            StRun: begin
               fwd_a_sel = fwd_a;
               fwd_b_sel = fwd_b;
               if (ex_redirect) begin
                  // PC loads the branch target; the wrong-path instruction in ID is dropped.
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
                  flush_ev    = 1'b1;
               end else begin
                  if (load_use || is_halt) begin
                     pc_write_en   = 1'b0;
                     ifid_write_en = 1'b0;
                     idex_bubble   = 1'b1;
                  end
                  stall_ev = load_use;
                  if (is_halt) begin
                     state_d = StDrain;
                     drain_d = 4'(DRAIN_CYCLES);
                  end
               end
            end
            StDrain: begin
               // Older instructions still in EX/MEM keep their forwarding paths.
               fwd_a_sel = fwd_a;
               fwd_b_sel = fwd_b;
               if (ex_redirect) begin
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
                  flush_ev    = 1'b1;
                  state_d     = StRun;
                  drain_d     = 4'd0;
               end else begin
                  pc_write_en   = 1'b0;
                  ifid_write_en = 1'b0;
                  idex_bubble   = 1'b1;
                  drain_d       = drain_q - 4'd1;
                  if (drain_q <= 4'd1) state_d = StHalted;
               end
            end
            StHalted: begin
               pc_write_en   = 1'b0;
               ifid_write_en = 1'b0;
               idex_bubble   = 1'b1;
               halted        = 1'b1;
            end
            default: state_d = StRun;
         endcase
      end
      retire_ev = reset && !idex_bubble && id_valid;
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
      drain_q <= drain_d;
   end

`ifdef PIPE_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic [CNT_W-1:0] stall_q, flush_q, retire_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_q  <= '0;
         flush_q  <= '0;
         retire_q <= '0;
      end else begin
         if (stall_ev && (stall_q != '1))   stall_q  <= stall_q + CntOne;
         if (flush_ev && (flush_q != '1))   flush_q  <= flush_q + CntOne;
         if (retire_ev && (retire_q != '1)) retire_q <= retire_q + CntOne;
      end
   end

   assign stall_count  = stall_q;
   assign flush_count  = flush_q;
   assign retire_count = retire_q;
`else
   logic unused_ev;
   assign unused_ev    = ^{stall_ev, flush_ev, retire_ev};
   assign stall_count  = '0;
   assign flush_count  = '0;
   assign retire_count = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a table of single-cycle RUN-state vectors followed
// by hand-written sequences for load-use, redirect, HALT drain and reset corner cases.
module tb_pipe_hazard_ctrl;

   localparam logic [5:0] OpAdd  = 6'b000000;
   localparam logic [5:0] OpHalt = 6'b010001;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid, id_uses_rt, ex_reg_write, ex_mem_read, mem_reg_write, ex_redirect;
   logic [5:0]  id_op;
   logic [4:0]  id_rs_add, id_rt_add, ex_rd_add, mem_rd_add;
   logic        pc_write_en, ifid_write_en, ifid_flush, idex_bubble, halted;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic [31:0] stall_count, flush_count, retire_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_rs_add(id_rs_add),
      .id_rt_add(id_rt_add), .id_uses_rt(id_uses_rt), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_rd_add(ex_rd_add), .mem_reg_write(mem_reg_write),
      .mem_rd_add(mem_rd_add), .ex_redirect(ex_redirect), .pc_write_en(pc_write_en),
      .ifid_write_en(ifid_write_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .halted(halted),
      .stall_count(stall_count), .flush_count(flush_count), .retire_count(retire_count)
   );

   typedef struct {
      string      name;
      logic       valid;
      logic [5:0] op;
      logic [4:0] rs, rt;
      logic       uses_rt, ex_rw, ex_mr;
      logic [4:0] ex_rd;
      logic       mem_rw;
      logic [4:0] mem_rd;
      logic       redir;
      logic       e_pc, e_ifid, e_flush, e_bub;
      logic [1:0] e_fa, e_fb;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected counter value: the counters read as 0 unless the feature is built in.
   function automatic logic [31:0] cexp(input logic [31:0] v);
`ifdef PIPE_PERF_CNT_EN
      return v;
`else
      return (v == 32'd0) ? 32'd0 : 32'd0;
`endif
   endfunction

   task automatic idle();
      id_valid = 0; id_op = OpAdd; id_rs_add = 0; id_rt_add = 0; id_uses_rt = 0;
      ex_reg_write = 0; ex_mem_read = 0; ex_rd_add = 0; mem_reg_write = 0; mem_rd_add = 0;
      ex_redirect = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 0;
      idle();
      @(negedge clk);
      reset = 1;
   endtask

   task automatic drive_halt();
      idle();
      id_valid = 1;
      id_op    = OpHalt;
   endtask

   initial begin
      vecs[0]  = '{"idle",          0, OpAdd, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'd0, 2'd0};
      vecs[1]  = '{"loaduse_rs",    1, OpAdd, 5, 6, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 2'd1, 2'd0};
      vecs[2]  = '{"rt_unused",     1, OpAdd, 1, 6, 0, 1, 1, 6, 0, 0, 0, 1, 1, 0, 0, 2'd0, 2'd0};
      vecs[3]  = '{"loaduse_rt",    1, OpAdd, 1, 6, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1};
      vecs[4]  = '{"ex_beats_mem",  1, OpAdd, 3, 0, 0, 1, 0, 3, 1, 3, 0, 1, 1, 0, 0, 2'd1, 2'd0};
      vecs[5]  = '{"r0_no_hazard",  1, OpAdd, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 2'd0, 2'd0};
      vecs[6]  = '{"mem_both",      1, OpAdd, 7, 7, 1, 0, 0, 0, 1, 7, 0, 1, 1, 0, 0, 2'd2, 2'd2};
      vecs[7]  = '{"mixed_fwd",     1, OpAdd, 9, 4, 1, 1, 0, 4, 1, 9, 0, 1, 1, 0, 0, 2'd2, 2'd1};
      vecs[8]  = '{"mem_no_write",  1, OpAdd, 7, 0, 0, 0, 0, 0, 0, 7, 0, 1, 1, 0, 0, 2'd0, 2'd0};
      vecs[9]  = '{"redir_loaduse", 1, OpAdd, 5, 0, 0, 1, 1, 5, 0, 0, 1, 1, 1, 1, 1, 2'd1, 2'd0};
      vecs[10] = '{"load_invalid",  0, OpAdd, 5, 0, 0, 1, 1, 5, 0, 0, 0, 1, 1, 0, 0, 2'd1, 2'd0};
      vecs[11] = '{"redir_halt",    1, OpHalt, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2'd0, 2'd0};

      // Outputs while reset is held low, with a forwarding pattern that must be masked.
      reset = 0;
      idle();
      id_valid = 1; id_rs_add = 3; ex_reg_write = 1; ex_rd_add = 3;
      @(negedge clk);
      #1;
      chk("rst_pc", 32'(pc_write_en), 1);
      chk("rst_ifid", 32'(ifid_write_en), 1);
      chk("rst_flush", 32'(ifid_flush), 0);
      chk("rst_bubble", 32'(idex_bubble), 1);
      chk("rst_fwd_a", 32'(fwd_a_sel), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_stall_cnt", stall_count, 0);
      chk("rst_retire_cnt", retire_count, 0);
      reset = 1;

      foreach (vecs[i]) begin
         @(negedge clk);
         id_valid = vecs[i].valid; id_op = vecs[i].op; id_rs_add = vecs[i].rs;
         id_rt_add = vecs[i].rt; id_uses_rt = vecs[i].uses_rt; ex_reg_write = vecs[i].ex_rw;
         ex_mem_read = vecs[i].ex_mr; ex_rd_add = vecs[i].ex_rd;
         mem_reg_write = vecs[i].mem_rw; mem_rd_add = vecs[i].mem_rd;
         ex_redirect = vecs[i].redir;
         #1;
         chk({vecs[i].name, ".pc"}, 32'(pc_write_en), 32'(vecs[i].e_pc));
         chk({vecs[i].name, ".ifid"}, 32'(ifid_write_en), 32'(vecs[i].e_ifid));
         chk({vecs[i].name, ".flush"}, 32'(ifid_flush), 32'(vecs[i].e_flush));
         chk({vecs[i].name, ".bubble"}, 32'(idex_bubble), 32'(vecs[i].e_bub));
         chk({vecs[i].name, ".fwd_a"}, 32'(fwd_a_sel), 32'(vecs[i].e_fa));
         chk({vecs[i].name, ".fwd_b"}, 32'(fwd_b_sel), 32'(vecs[i].e_fb));
      end

      // Load-use: one stall cycle, then the ADD issues with the load result from MEM.
      do_reset();
      idle();
      id_valid = 1; id_rs_add = 5; ex_reg_write = 1; ex_mem_read = 1; ex_rd_add = 5;
      #1;
      chk("lu_stall_pc", 32'(pc_write_en), 0);
      chk("lu_stall_bub", 32'(idex_bubble), 1);
      @(negedge clk);
      ex_reg_write = 0; ex_mem_read = 0; ex_rd_add = 0; mem_reg_write = 1; mem_rd_add = 5;
      #1;
      chk("lu_issue_pc", 32'(pc_write_en), 1);
      chk("lu_issue_bub", 32'(idex_bubble), 0);
      chk("lu_issue_fwd_a", 32'(fwd_a_sel), 2);
      chk("lu_stall_cnt", stall_count, cexp(1));
      @(negedge clk);
      idle();
      #1;
      chk("lu_stall_cnt2", stall_count, cexp(1));
      chk("lu_retire_cnt", retire_count, cexp(1));

      // Redirect wins over a simultaneous load-use hazard.
      do_reset();
      idle();
      id_valid = 1; id_rs_add = 5; ex_reg_write = 1; ex_mem_read = 1; ex_rd_add = 5;
      ex_redirect = 1;
      #1;
      chk("rd_flush", 32'(ifid_flush), 1);
      chk("rd_pc", 32'(pc_write_en), 1);
      @(negedge clk);
      idle();
      #1;
      chk("rd_flush_cnt", flush_count, cexp(1));
      chk("rd_stall_cnt", stall_count, cexp(0));

      // HALT drain: halted rises on the 4th edge counting the one that samples HALT.
      do_reset();
      drive_halt();
      #1;
      chk("halt_dec_pc", 32'(pc_write_en), 0);
      chk("halt_dec_bub", 32'(idex_bubble), 1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         idle();
         if (k == 1) begin
            ex_reg_write = 1; ex_rd_add = 3; id_rs_add = 3;
         end
         #1;
         chk($sformatf("halt_halted_%0d", k), 32'(halted), (k == 4) ? 1 : 0);
         chk($sformatf("halt_pc_%0d", k), 32'(pc_write_en), 0);
         if (k == 1) chk("drain_fwd_a", 32'(fwd_a_sel), 1);
      end
      @(negedge clk);
      idle();
      id_valid = 1; ex_reg_write = 1; ex_rd_add = 3; id_rs_add = 3;
      #1;
      chk("halted_stays", 32'(halted), 1);
      chk("halted_fwd_a", 32'(fwd_a_sel), 0);
      chk("halted_bub", 32'(idex_bubble), 1);

      // HALT discarded by a redirect never starts a drain.
      do_reset();
      drive_halt();
      ex_redirect = 1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         idle();
         #1;
         chk($sformatf("hr_halted_%0d", k), 32'(halted), 0);
         chk($sformatf("hr_pc_%0d", k), 32'(pc_write_en), 1);
      end

      // Redirect during DRAIN returns to RUN.
      do_reset();
      drive_halt();
      @(negedge clk);
      idle();
      ex_redirect = 1;
      #1;
      chk("dr_flush", 32'(ifid_flush), 1);
      chk("dr_pc", 32'(pc_write_en), 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         idle();
         #1;
         chk($sformatf("dr_run_pc_%0d", k), 32'(pc_write_en), 1);
         chk($sformatf("dr_halted_%0d", k), 32'(halted), 0);
      end

      // Reset pulse mid-drain clears state and counters.
      do_reset();
      idle();
      ex_redirect = 1;
      @(negedge clk);
      drive_halt();
      @(negedge clk);
      idle();
      #1;
      chk("rd_drain_pc", 32'(pc_write_en), 0);
      chk("rd_drain_flush_cnt", flush_count, cexp(1));
      reset = 0;
      id_valid = 1; ex_reg_write = 1; ex_rd_add = 3; id_rs_add = 3;
      #1;
      chk("rd_low_pc", 32'(pc_write_en), 1);
      chk("rd_low_bub", 32'(idex_bubble), 1);
      chk("rd_low_fwd_a", 32'(fwd_a_sel), 0);
      @(negedge clk);
      reset = 1;
      idle();
      #1;
      chk("rd_after_pc", 32'(pc_write_en), 1);
      chk("rd_after_halted", 32'(halted), 0);
      chk("rd_after_flush_cnt", flush_count, 0);
      chk("rd_after_retire_cnt", retire_count, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("rd_run_halted_%0d", k), 32'(halted), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
